// File: rtl/basic_cache_refill.sv
// Refill controller in front of a 256-entry direct-mapped cache: one-cycle lookup,
// single outstanding memory read on a miss, flush of the in-flight request, hit/miss counters.
module basic_cache_refill #(
    parameter int ALEN  = 32,
    parameter int CNT_W = 16,
    parameter int AW    = ALEN - 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ALEN-1:0]   req_addr,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [63:0]       resp_data,
    output logic [AW-1:0]     cache_raddr,
    input  logic [63:0]       cache_rdata,
    input  logic              cache_lookup_valid,
    output logic              cache_write_enable,
    output logic [AW-1:0]     cache_waddr,
    output logic [63:0]       cache_wdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AW-1:0]     mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_data,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        DRAIN     = 3'd4,
        RESP      = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            state_r;
    logic [AW-1:0]     addr_r;
    logic [63:0]       data_r;
    logic [CNT_W-1:0]  hit_cnt_r;
    logic [CNT_W-1:0]  miss_cnt_r;
    logic              refill_window_s;
    logic [2:0]        addr_lsb_unused_s;

    // Byte offset within the doubleword carries no information for this block.
    assign addr_lsb_unused_s = req_addr[2:0];

    // A memory beat is only accepted while a refill is actually outstanding.
    assign refill_window_s = (state_r == MISS_WAIT) || (state_r == DRAIN);

    // Output decodes of the registered state; cache write path stays combinational from memory.
    always_comb begin
        req_ready          = (state_r == IDLE);
        resp_valid         = (state_r == RESP);
        mem_req_valid      = (state_r == MISS_REQ);
        resp_data          = data_r;
        mem_req_addr       = addr_r;
        cache_waddr        = addr_r;
        cache_wdata        = mem_resp_data;
        cache_write_enable = refill_window_s && mem_resp_valid;
        hit_count          = hit_cnt_r;
        miss_count         = miss_cnt_r;
        if (state_r == IDLE) begin
            cache_raddr = req_addr[ALEN-1:3];
        end else begin
            cache_raddr = addr_r;
        end
    end

    // Request/refill state machine with address, data and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            addr_r     <= {AW{1'b0}};
            data_r     <= 64'd0;
            hit_cnt_r  <= {CNT_W{1'b0}};
            miss_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && !flush) begin
                        addr_r  <= req_addr[ALEN-1:3];
                        state_r <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    // Counters record the lookup outcome even when it is flushed.
                    if (cache_lookup_valid) begin
                        hit_cnt_r <= hit_cnt_r + CNT_ONE;
                        if (flush) begin
                            state_r <= IDLE;
                        end else begin
                            data_r  <= cache_rdata;
                            state_r <= RESP;
                        end
                    end else begin
                        miss_cnt_r <= miss_cnt_r + CNT_ONE;
                        state_r    <= flush ? IDLE : MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    // Once the handshake happens the response must be drained even if flushed.
                    if (mem_req_ready) begin
                        state_r <= flush ? DRAIN : MISS_WAIT;
                    end else if (flush) begin
                        state_r <= IDLE;
                    end
                end
                MISS_WAIT: begin
                    if (mem_resp_valid) begin
                        data_r  <= mem_resp_data;
                        state_r <= flush ? IDLE : RESP;
                    end else if (flush) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_resp_valid) begin
                        state_r <= IDLE;
                    end
                end
                RESP: begin
                    if (resp_ready || flush) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_basic_cache_refill.sv
// Directed bench for basic_cache_refill with a small behavioural model of the downstream cache.
module tb_basic_cache_refill;

    localparam int ALEN  = 32;
    localparam int CNT_W = 16;
    localparam int AW    = ALEN - 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [ALEN-1:0]   req_addr;
    logic              flush;
    logic              resp_valid;
    logic              resp_ready;
    logic [63:0]       resp_data;
    logic [AW-1:0]     cache_raddr;
    logic [63:0]       cache_rdata;
    logic              cache_lookup_valid;
    logic              cache_write_enable;
    logic [AW-1:0]     cache_waddr;
    logic [63:0]       cache_wdata;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_resp_valid;
    logic [63:0]       mem_resp_data;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    int checks   = 0;
    int failures = 0;

    basic_cache_refill #(.ALEN(ALEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .cache_raddr(cache_raddr), .cache_rdata(cache_rdata),
        .cache_lookup_valid(cache_lookup_valid),
        .cache_write_enable(cache_write_enable), .cache_waddr(cache_waddr),
        .cache_wdata(cache_wdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Cache model: 256 lines, registered read address, read-after-write visible next lookup.
    logic [63:0]   c_data [256];
    logic [AW-9:0] c_tag  [256];
    logic          c_val  [256] = '{default: 1'b0};
    logic [AW-1:0] c_raddr_q = '0;
    int            wr_cnt = 0;

    always @(posedge clk) begin
        c_raddr_q <= cache_raddr;
        if (cache_write_enable) begin
            c_data[cache_waddr[7:0]] <= cache_wdata;
            c_tag[cache_waddr[7:0]]  <= cache_waddr[AW-1:8];
            c_val[cache_waddr[7:0]]  <= 1'b1;
            wr_cnt <= wr_cnt + 1;
        end
    end

    assign cache_rdata        = c_data[c_raddr_q[7:0]];
    assign cache_lookup_valid = c_val[c_raddr_q[7:0]] && (c_tag[c_raddr_q[7:0]] == c_raddr_q[AW-1:8]);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int wr_before;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = 32'h0; flush = 1'b0;
        resp_ready = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 64'h0;
        tick(); tick();
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_mem_req_valid", {63'd0, mem_req_valid}, 64'd0);
        check("rst_cache_we", {63'd0, cache_write_enable}, 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_counts", {32'd0, hit_count, miss_count}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Cold miss on 0x1000
        req_valid = 1'b1; req_addr = 32'h0000_1000;
        #1 check("cold_raddr_idle", {35'd0, cache_raddr}, 64'h200);
        tick();
        req_valid = 1'b0;
        check("cold_lookup_not_ready", {63'd0, req_ready}, 64'd0);
        tick();
        check("cold_mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
        check("cold_mem_req_addr", {35'd0, mem_req_addr}, 64'h200);
        check("cold_miss_count", {48'd0, miss_count}, 64'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("cold_wait_no_req", {63'd0, mem_req_valid}, 64'd0);
        tick(); tick();
        mem_resp_valid = 1'b1; mem_resp_data = 64'hDEADBEEF_CAFEF00D;
        #1;
        check("cold_cache_we", {63'd0, cache_write_enable}, 64'd1);
        check("cold_cache_waddr", {35'd0, cache_waddr}, 64'h200);
        check("cold_cache_wdata", cache_wdata, 64'hDEADBEEF_CAFEF00D);
        tick();
        mem_resp_valid = 1'b0;
        check("cold_resp_valid", {63'd0, resp_valid}, 64'd1);
        check("cold_resp_data", resp_data, 64'hDEADBEEF_CAFEF00D);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("cold_back_idle", {62'd0, req_ready, resp_valid}, 64'd2);

        // Hit after fill
        req_valid = 1'b1; req_addr = 32'h0000_1000;
        tick();
        req_valid = 1'b0;
        tick();
        check("hit_resp_valid", {63'd0, resp_valid}, 64'd1);
        check("hit_no_mem_req", {63'd0, mem_req_valid}, 64'd0);
        check("hit_resp_data", resp_data, 64'hDEADBEEF_CAFEF00D);
        check("hit_count_1", {48'd0, hit_count}, 64'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Conflict on index 0 with backpressure on both sides
        req_valid = 1'b1; req_addr = 32'h0000_1800;
        tick();
        req_valid = 1'b0;
        tick();
        check("conf_miss_count", {48'd0, miss_count}, 64'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp_mem_req_valid", {63'd0, mem_req_valid}, 64'd1);
            check("bp_mem_req_addr", {35'd0, mem_req_addr}, 64'h300);
            check("bp_req_ready_low", {63'd0, req_ready}, 64'd0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 64'h1111_2222_3333_4444;
        tick();
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("bp_resp_valid", {63'd0, resp_valid}, 64'd1);
            check("bp_resp_data", resp_data, 64'h1111_2222_3333_4444);
            check("bp_req_ready_low2", {63'd0, req_ready}, 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0000_1000;
        tick();
        req_valid = 1'b0;
        tick();
        check("conf_remiss_req", {63'd0, mem_req_valid}, 64'd1);
        check("conf_miss_count_3", {48'd0, miss_count}, 64'd3);
        check("conf_hit_unchanged", {48'd0, hit_count}, 64'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = 64'hDEADBEEF_CAFEF00D;
        tick();
        mem_resp_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Flush while a request is offered in IDLE: not accepted
        req_valid = 1'b1; flush = 1'b1; req_addr = 32'h0000_2008;
        tick();
        req_valid = 1'b0; flush = 1'b0;
        check("flush_idle_no_accept", {63'd0, req_ready}, 64'd1);

        // Flush in MISS_WAIT goes through DRAIN and still fills the cache
        req_valid = 1'b1; req_addr = 32'h0000_2008;
        tick();
        req_valid = 1'b0;
        tick();
        check("fl_miss_count_4", {48'd0, miss_count}, 64'd4);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_drain_no_resp", {62'd0, req_ready, resp_valid}, 64'd0);
        tick();
        mem_resp_valid = 1'b1; mem_resp_data = 64'hA5A5_5A5A_0F0F_F0F0;
        #1 check("fl_drain_cache_we", {63'd0, cache_write_enable}, 64'd1);
        check("fl_drain_waddr", {35'd0, cache_waddr}, 64'h401);
        tick();
        mem_resp_valid = 1'b0;
        check("fl_after_drain_idle", {62'd0, req_ready, resp_valid}, 64'd2);
        req_valid = 1'b1; req_addr = 32'h0000_2008;
        tick();
        req_valid = 1'b0;
        tick();
        check("fl_rehit_valid", {63'd0, resp_valid}, 64'd1);
        check("fl_rehit_data", resp_data, 64'hA5A5_5A5A_0F0F_F0F0);
        check("fl_hit_count_2", {48'd0, hit_count}, 64'd2);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Flush during LOOKUP: no response, hit still counted
        req_valid = 1'b1; req_addr = 32'h0000_1000;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_lookup_idle", {62'd0, req_ready, resp_valid}, 64'd2);
        check("fl_lookup_hit_count", {48'd0, hit_count}, 64'd3);

        // Reset during MISS_WAIT, then a late memory response
        req_valid = 1'b1; req_addr = 32'h0000_3010;
        tick();
        req_valid = 1'b0;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1 check("rst_mid_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_mid_counts", {32'd0, hit_count, miss_count}, 64'd0);
        tick();
        rst_n = 1'b1;
        wr_before = wr_cnt;
        mem_resp_valid = 1'b1; mem_resp_data = 64'h0123_4567_89AB_CDEF;
        #1 check("rst_late_no_we", {63'd0, cache_write_enable}, 64'd0);
        tick();
        mem_resp_valid = 1'b0;
        check("rst_late_idle", {62'd0, req_ready, resp_valid}, 64'd2);
        check("rst_late_no_write", 64'(wr_cnt), 64'(wr_before));
        check("rst_late_counts", {32'd0, hit_count, miss_count}, 64'd0);
        check("rst_late_resp_data", resp_data, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
